// File: rtl/icache_fill_if.sv
// Fetch-side request/response and RAM line-read signals of the instruction cache.
// The cache is the slave on this bundle. The fetch unit and RAM environment are the master.
interface icache_fill_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_WIDTH  = 128
);
  logic                  flush;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_inst;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [RAM_WIDTH-1:0]  mem_dout;

  modport slave (
    input  flush, req_valid, req_addr, mem_dout,
    output req_ready, resp_valid, resp_inst, mem_en, mem_addr
  );

  modport master (
    output flush, req_valid, req_addr, mem_dout,
    input  req_ready, resp_valid, resp_inst, mem_en, mem_addr
  );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache. Hits answer in one cycle.
// On a miss, a whole line is read from the RAM line port and installed after FILL_CYCLES.
module icache_line #(
  parameter int TAG_W     = 9,
  parameter int RAM_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 wr_valid,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [RAM_WIDTH-1:0] wr_data,
  output logic                 valid,
  output logic [TAG_W-1:0]     tag,
  output logic [RAM_WIDTH-1:0] data
);
  // Flush wins over a same-cycle install, so a line filled under flush stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (clr)   valid <= 1'b0;
    else if (wr)    valid <= wr_valid;
  end

  // Tag and data carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr) begin
      tag  <= wr_tag;
      data <= wr_data;
    end
  end
endmodule

module icache_fill #(
  parameter int ADDR_WIDTH  = 17,
  parameter int RAM_WIDTH   = 128,
  parameter int INDEX_WIDTH = 4,
  parameter int FILL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_fill_if.slave  bus
);
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 4;
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int CNT_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [INDEX_WIDTH-1:0]          req_index, fill_index;
  logic [TAG_W-1:0]                req_tag, fill_tag;
  logic [1:0]                      req_word, fill_word;
  logic [LINES-1:0]                line_valid;
  logic [LINES-1:0][TAG_W-1:0]     line_tag;
  logic [LINES-1:0][RAM_WIDTH-1:0] line_data;
  logic                            accept, hit, start_fill, fill_done;
  logic                            flush_flag, line_wr_valid;
  logic                            unused_addr;

  assign req_index   = bus.req_addr[INDEX_WIDTH+3:4];
  assign req_tag     = bus.req_addr[ADDR_WIDTH-1:INDEX_WIDTH+4];
  assign req_word    = bus.req_addr[3:2];
  assign unused_addr = ^bus.req_addr[1:0];

  assign bus.req_ready = (state == IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign hit           = line_valid[req_index] && (line_tag[req_index] == req_tag);
  // A flush anywhere in the fill, including its final cycle, keeps the new line invalid.
  assign line_wr_valid = !(flush_flag || bus.flush);

  for (genvar i = 0; i < LINES; i++) begin : g_line
    icache_line #(.TAG_W(TAG_W), .RAM_WIDTH(RAM_WIDTH)) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.flush),
      .wr       (fill_done && (fill_index == INDEX_WIDTH'(i))),
      .wr_valid (line_wr_valid),
      .wr_tag   (fill_tag),
      .wr_data  (bus.mem_dout),
      .valid    (line_valid[i]),
      .tag      (line_tag[i]),
      .data     (line_data[i])
    );
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !hit) begin
          start_fill = 1'b1;
          cnt_nxt    = CNT_W'(FILL_CYCLES - 1);
          state_nxt  = FILL;
        end
      end
      FILL: begin
        if (cnt == '0) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      flush_flag     <= 1'b0;
      fill_index     <= '0;
      fill_tag       <= '0;
      fill_word      <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_inst  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_flag <= (state == FILL) && !fill_done && (flush_flag || bus.flush);

      bus.resp_valid <= (accept && hit) || fill_done;
      if (accept && hit)
        bus.resp_inst <= line_data[req_index][{req_word, 5'b0} +: 32];
      else if (fill_done)
        bus.resp_inst <= bus.mem_dout[{fill_word, 5'b0} +: 32];

      if (start_fill) begin
        bus.mem_en   <= 1'b1;
        bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:4], 4'b0};
        fill_index   <= req_index;
        fill_tag     <= req_tag;
        fill_word    <= req_word;
      end else if (fill_done) begin
        bus.mem_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: directed vector table, reset and flush sequences,
// then random fetches against an address-level cache model.
module tb_icache_fill;
  localparam int AW = 17, RW = 128, IW = 4, FC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] salt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  icache_fill_if #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) bus ();

  icache_fill #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .INDEX_WIDTH(IW), .FILL_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM contents: byte a = a[7:0] + 37*a[16:8], xored with a changeable salt.
  function automatic logic [RW-1:0] ram_line(input logic [AW-1:0] base, input logic [7:0] s);
    logic [RW-1:0] l;
    logic [7:0]    hi;
    hi = 8'(int'(base[16:8]) * 37);
    for (int j = 0; j < 16; j++)
      l[j*8 +: 8] = (base[7:0] + 8'(j) + hi) ^ s;
    return l;
  endfunction

  always_comb bus.mem_dout = ram_line(bus.mem_addr, salt);

  // Reference model: which line base each index holds, and the line captured at fill time.
  bit            mvalid [16];
  int            mtag   [16];
  logic [RW-1:0] mdata  [16];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after a negedge with req_valid low.
  task automatic fetch(input logic [AW-1:0] a, input int flush_at, input bit exp_hit,
                       input logic [31:0] exp_inst, input string nm);
    logic [AW-1:0] base;
    bit fl;
    int idx;
    base = {a[AW-1:4], 4'b0};
    idx  = int'(a[7:4]);
    fl   = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.flush     = 1'b0;
    #1 chk({nm, " ready"}, bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = AW'($urandom);
    if (exp_hit) begin
      chk({nm, " hit resp_valid"}, bus.resp_valid, 1);
      chk({nm, " hit inst"}, bus.resp_inst, exp_inst);
      chk({nm, " hit mem_en"}, bus.mem_en, 0);
    end else begin
      for (int k = 0; k < FC; k++) begin
        if (k > 0) @(negedge clk);
        bus.flush = (k == flush_at);
        if (k == flush_at) fl = 1'b1;
        #1;
        chk({nm, " fill mem_en"}, bus.mem_en, 1);
        chk({nm, " fill mem_addr"}, bus.mem_addr, base);
        chk({nm, " fill resp_valid"}, bus.resp_valid, 0);
        chk({nm, " fill ready"}, bus.req_ready, 0);
      end
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk({nm, " miss resp_valid"}, bus.resp_valid, 1);
      chk({nm, " miss inst"}, bus.resp_inst, exp_inst);
      chk({nm, " miss ready"}, bus.req_ready, 1);
      chk({nm, " miss mem_en"}, bus.mem_en, 0);
      if (fl) model_clear();
      else begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = int'(a[16:8]);
        mdata[idx]  = ram_line(base, salt);
      end
    end
  endtask

  task automatic idle_flush(input logic [AW-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.flush     = 1'b1;
    #1 chk("flush_idle ready", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_idle resp_valid", bus.resp_valid, 0);
    chk("flush_idle mem_en", bus.mem_en, 0);
    model_clear();
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle resp_valid", bus.resp_valid, 0);
    chk("idle mem_en", bus.mem_en, 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            flush_at;
    bit            hit;
    logic [31:0]   inst;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [AW-1:0] a;
    logic [RW-1:0] line;
    int idx, fa, r;
    bit h;

    vecs[0] = '{17'h00004, -1, 1'b0, 32'h07060504};  // cold miss
    vecs[1] = '{17'h0000C, -1, 1'b1, 32'h0F0E0D0C};  // hit
    vecs[2] = '{17'h00000, -1, 1'b1, 32'h03020100};  // back-to-back hits
    vecs[3] = '{17'h00008, -1, 1'b1, 32'h0B0A0908};
    vecs[4] = '{17'h00100, -1, 1'b0, 32'h28272625};  // conflict on index 0
    vecs[5] = '{17'h00004, -1, 1'b0, 32'h07060504};  // evicted line misses again
    vecs[6] = '{17'h00020,  0, 1'b0, 32'h23222120};  // flush in first fill cycle
    vecs[7] = '{17'h00020, -1, 1'b0, 32'h23222120};  // not installed, misses again
    vecs[8] = '{17'h00024, -1, 1'b1, 32'h27262524};

    salt          = 8'h00;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    rst_n         = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset ready", bus.req_ready, 1);
    chk("reset resp_valid", bus.resp_valid, 0);
    chk("reset resp_inst", bus.resp_inst, 0);
    chk("reset mem_en", bus.mem_en, 0);
    chk("reset mem_addr", bus.mem_addr, 0);

    for (int i = 0; i < 9; i++)
      fetch(vecs[i].addr, vecs[i].flush_at, vecs[i].hit, vecs[i].inst, $sformatf("vec%0d", i));

    idle_cycle();
    idle_flush(17'h00024);
    fetch(17'h00024, -1, 1'b0, 32'h27262524, "post_flush_miss");

    // Reset in the second fill cycle: everything drops at once, no response follows.
    bus.req_valid = 1'b1;
    bus.req_addr  = 17'h00030;
    #1 chk("rstfill ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstfill mem_en", bus.mem_en, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstfill async mem_en", bus.mem_en, 0);
    chk("rstfill async mem_addr", bus.mem_addr, 0);
    chk("rstfill async resp_valid", bus.resp_valid, 0);
    chk("rstfill async resp_inst", bus.resp_inst, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rstfill no resp", bus.resp_valid, 0);
    rst_n = 1'b1;
    model_clear();
    fetch(17'h00030, -1, 1'b0, 32'h33323130, "rstfill retry");
    fetch(17'h00024, -1, 1'b0, 32'h27262524, "rstfill other miss");

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        idle_flush(AW'($urandom));
      end else if (r < 8) begin
        salt = 8'($urandom);
        idle_cycle();
      end else begin
        if (r < 12) a = AW'($urandom);
        else a = {7'($urandom_range(0, 2)), 6'($urandom), 4'($urandom)};
        idx  = int'(a[7:4]);
        h    = mvalid[idx] && (mtag[idx] == int'(a[16:8]));
        line = h ? mdata[idx] : ram_line({a[AW-1:4], 4'b0}, salt);
        fa   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FC-1)) : -1;
        fetch(a, fa, h, line[{a[3:2], 5'b0} +: 32], "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
